// File: rtl/spi_cmd_decoder_pkg.sv
// Shared definitions for the SPI command decoder: opcode values, FSM states
// and the default memory address width.
package spi_cmd_decoder_pkg;

  localparam int ADDR_W_DEF = 24;

  localparam logic [3:0] CMD_NOP       = 4'h0;
  localparam logic [3:0] CMD_SET_ADDR  = 4'h1;
  localparam logic [3:0] CMD_WRITE     = 4'h2;
  localparam logic [3:0] CMD_READ      = 4'h3;
  localparam logic [3:0] CMD_SET_FLAGS = 4'h4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// Turns the SPI slave byte stream into MCU commands: address load, streamed
// memory write, prefetching memory read and flag write; drives the MISO byte.
module spi_cmd_decoder
  import spi_cmd_decoder_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int ADDR_BYTES = ADDR_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_ready,
  input  logic              param_ready,
  input  logic [7:0]        cmd_data,
  input  logic [7:0]        param_data,
  input  logic              startmessage,
  input  logic              endmessage,
  output logic [7:0]        spi_out_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        flags,
  output logic              overrun
);

  state_t            state;
  state_t            next_state;
  logic [3:0]        cmd;
  logic [3:0]        cmd_op;
  logic [3:0]        unused_cmd_low;
  logic [1:0]        param_idx;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rd_byte;
  logic              pend_read;
  logic              param_fire;
  logic              issue;

  assign cmd_op         = cmd_data[7:4];
  assign unused_cmd_low = cmd_data[3:0];
  assign param_fire     = param_ready && !cmd_ready;
  assign mem_req        = (state == ST_REQ);
  assign spi_out_data   = (cmd == CMD_READ) ? rd_byte : {overrun, state == ST_REQ, 6'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // A READ opcode arriving while a request is still in flight is remembered
  // in pend_read and issued as soon as the FSM returns to idle.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_ready)       issue = (cmd_op == CMD_READ);
        else if (param_fire) issue = (cmd == CMD_WRITE) || (cmd == CMD_READ);
        else if (pend_read)  issue = (cmd == CMD_READ);
        if (issue) next_state = ST_REQ;
      end
      ST_REQ: if (mem_ack) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd       <= CMD_NOP;
      param_idx <= 2'd0;
      addr      <= '0;
      rd_byte   <= 8'h00;
      pend_read <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      flags     <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      // Completions land even after start/end of message; read data is only
      // kept while a READ command is still active.
      if (state == ST_REQ && mem_ack) begin
        if (mem_we)               addr    <= addr + ADDR_W'(1);
        else if (cmd == CMD_READ) rd_byte <= mem_rdata;
      end

      if (startmessage) overrun <= 1'b0;

      if (cmd_ready) begin
        cmd       <= cmd_op;
        param_idx <= 2'd0;
        pend_read <= (cmd_op == CMD_READ) && (state == ST_REQ);
        if (issue) begin
          mem_we   <= 1'b0;
          mem_addr <= addr;
        end
      end else begin
        if (startmessage || endmessage) begin
          cmd       <= CMD_NOP;
          pend_read <= 1'b0;
        end
        if (param_fire) begin
          if (param_idx != 2'd3) param_idx <= param_idx + 2'd1;
          if (state == ST_REQ) begin
            overrun <= 1'b1;
          end else begin
            unique case (cmd)
              CMD_SET_ADDR:
                if (int'(param_idx) < ADDR_BYTES) addr <= {addr[ADDR_W-9:0], param_data};
              CMD_WRITE: begin
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= param_data;
              end
              CMD_READ: begin
                addr     <= addr + ADDR_W'(1);
                mem_we   <= 1'b0;
                mem_addr <= addr + ADDR_W'(1);
              end
              CMD_SET_FLAGS:
                if (param_idx == 2'd0) flags <= param_data;
              default: ;
            endcase
          end
        end else if (issue) begin
          mem_we    <= 1'b0;
          mem_addr  <= addr;
          pend_read <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a behavioural memory answers requests,
// expected memory transactions are queued by the stimulus and checked by a monitor.
module tb_spi_cmd_decoder;
  import spi_cmd_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_ready = 1'b0;
  logic        param_ready = 1'b0;
  logic [7:0]  cmd_data = 8'h00;
  logic [7:0]  param_data = 8'h00;
  logic        startmessage = 1'b0;
  logic        endmessage = 1'b0;
  logic [7:0]  spi_out_data;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  flags;
  logic        overrun;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         ack_delay = 1;
  int         ack_cnt = 0;
  logic       req_prev = 1'b0;
  logic [7:0] mem [0:65535];

  spi_cmd_decoder dut (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data), .startmessage(startmessage),
    .endmessage(endmessage), .spi_out_data(spi_out_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .flags(flags), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Memory model: acknowledges a held request after ack_delay falling edges.
  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_rdata = mem[mem_addr[15:0]];
        if (mem_we) mem[mem_addr[15:0]] = mem_wdata;
        mem_ack = 1'b1;
        ack_cnt = 0;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  // Monitor: every new request is compared against the head of the queue.
  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL mem_txn: unexpected request we=%0b addr=%06h wdata=%02h", mem_we, mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
          bad++;
          $display("[TB] FAIL mem_txn: got we=%0b addr=%06h wdata=%02h, want we=%0b addr=%06h wdata=%02h",
                   mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
        end
      end
    end
    req_prev = mem_req;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic expect_txn(input logic we, input logic [23:0] addr, input logic [7:0] wdata);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata;
    exp_q.push_back(e);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    cmd_data = b; cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
  endtask

  task automatic send_param(input logic [7:0] b);
    @(negedge clk);
    param_data = b; param_ready = 1'b1;
    @(negedge clk);
    param_ready = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); startmessage = 1'b1;
    @(negedge clk); startmessage = 1'b0;
  endtask

  task automatic pulse_end();
    @(negedge clk); endmessage = 1'b1;
    @(negedge clk); endmessage = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mem_req) begin
      total++; bad++;
      $display("[TB] FAIL wait_idle: mem_req still 1 after %0d cycles, want 0", n);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] c, input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input int np);
    send_cmd(c);
    if (np > 0) send_param(p0);
    if (np > 1) send_param(p1);
    if (np > 2) send_param(p2);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0100] = 8'h5A;
    mem[16'h0101] = 8'hC3;
    repeat (3) @(negedge clk);
    check_output("reset_spi_out", spi_out_data, 8'h00);
    check_output("reset_mem_req", mem_req, 1'b0);
    check_output("reset_flags", flags, 8'h00);
    check_output("reset_overrun", overrun, 1'b0);
    rst = 1'b0;
    pulse_start();

    // Address load, then a write proves where it landed
    apply_stimulus(8'h10, 8'h12, 8'h34, 8'h56, 3);
    check_output("set_addr_no_req", mem_req, 1'b0);
    check_output("set_addr_flags", flags, 8'h00);
    check_output("set_addr_status", spi_out_data, 8'h00);
    expect_txn(1'b1, 24'h123456, 8'h77);
    apply_stimulus(8'h20, 8'h77, 8'h00, 8'h00, 1);
    wait_idle();

    // Flags: only first param taken, low nibble of cmd ignored
    apply_stimulus(8'h4F, 8'hA5, 8'h3C, 8'h00, 2);
    check_output("set_flags", flags, 8'hA5);

    // Streamed write
    apply_stimulus(8'h10, 8'h00, 8'h00, 8'h10, 3);
    send_cmd(8'h20);
    expect_txn(1'b1, 24'h000010, 8'hAA); send_param(8'hAA); wait_idle();
    expect_txn(1'b1, 24'h000011, 8'hBB); send_param(8'hBB); wait_idle();
    expect_txn(1'b1, 24'h000012, 8'hCC); send_param(8'hCC); wait_idle();

    // Streamed read with prefetch
    apply_stimulus(8'h10, 8'h00, 8'h01, 8'h00, 3);
    expect_txn(1'b0, 24'h000100, 8'h00);
    send_cmd(8'h30);
    wait_idle();
    check_output("read_first", spi_out_data, 8'h5A);
    expect_txn(1'b0, 24'h000101, 8'h00);
    send_param(8'h00);
    wait_idle();
    check_output("read_prefetch", spi_out_data, 8'hC3);
    check_output("read_addr", mem_addr, 24'h000101);
    pulse_end();
    check_output("end_status", spi_out_data, 8'h00);

    // Overrun on a param arriving during a slow request
    ack_delay = 20;
    apply_stimulus(8'h10, 8'h00, 8'h02, 8'h00, 3);
    send_cmd(8'h20);
    expect_txn(1'b1, 24'h000200, 8'h11);
    send_param(8'h11);
    repeat (3) @(negedge clk);
    send_param(8'h22);
    check_output("overrun_set", overrun, 1'b1);
    check_output("overrun_status", spi_out_data, 8'hC0);
    wait_idle();
    check_output("overrun_sticky", spi_out_data, 8'h80);
    pulse_start();
    check_output("overrun_cleared", overrun, 1'b0);
    ack_delay = 1;
    expect_txn(1'b1, 24'h000201, 8'h33);
    apply_stimulus(8'h20, 8'h33, 8'h00, 8'h00, 1);
    wait_idle();

    // Address wrap
    apply_stimulus(8'h10, 8'hFF, 8'hFF, 8'hFF, 3);
    send_cmd(8'h20);
    expect_txn(1'b1, 24'hFFFFFF, 8'h01); send_param(8'h01); wait_idle();
    expect_txn(1'b1, 24'h000000, 8'h02); send_param(8'h02); wait_idle();

    // Async reset during a request
    ack_delay = 50;
    expect_txn(1'b1, 24'h000001, 8'h44);
    send_param(8'h44);
    check_output("pre_rst_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    check_output("rst_mem_req", mem_req, 1'b0);
    check_output("rst_flags", flags, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    ack_delay = 1;
    expect_txn(1'b1, 24'h000000, 8'h55);
    apply_stimulus(8'h20, 8'h55, 8'h00, 8'h00, 1);
    wait_idle();

    repeat (3) @(negedge clk);
    check_output("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
